random_engine_dpath: RTL and testbench

Datapath stage driven by the random-engine control FSM. It advances a Fibonacci LFSR one step on every cycle `lfsr_en` is high, and packs the serial output bits MSB-first into OUT_W-bit words. Completed words pass through a 2-entry output FIFO to the consumer over a val/rdy handshake. The LFSR cannot be stalled, so a word that arrives while the FIFO is full is dropped and a sticky `overflow` flag is raised.

---
 rtl/random_engine_dpath.sv | 146 ++++++++++++++
 tb/tb_random_engine_dpath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_engine_dpath.sv
// Small synchronous FIFO with in-order storage; DEPTH must be a power of two.
// Latency: a written word is visible on rd_dat/rd_vld the cycle after the write edge.
// Backpressure: full refuses a write unless the same cycle pops; the caller decides what to do with a refused word.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          rd_fire;
    logic          wr_fire;

    assign full    = (cnt == FULL_CNT);
    assign rd_vld  = (cnt != '0);
    assign rd_fire = rd_vld & rd_rdy;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_fire = wr_vld & (~full | rd_fire);
    // Empty FIFO presents zero rather than stale storage.
    assign rd_dat  = rd_vld ? mem[rptr] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_fire) wptr <= wptr + 1'b1;
            if (rd_fire) rptr <= rptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates the read side.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wptr] <= wr_dat;
    end
endmodule

// Fibonacci LFSR bit source packed MSB-first into OUT_W-bit words behind a 2-entry FIFO.
// Latency: a word appears on out_val/out_data the cycle after the OUT_W-th enabled step.
// Backpressure: the LFSR never stalls; a word completing into a full FIFO with no pop is dropped and overflow sticks.
module random_engine_dpath #(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1,
    parameter int                OUT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lfsr_en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic              overflow,
    output logic [LFSR_W-1:0] lfsr_state
);
    localparam int            CW   = $clog2(OUT_W);
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    logic [LFSR_W-1:0] lfsr;
    logic [OUT_W-2:0]  sr;
    logic [CW-1:0]     cnt;
    logic              step_en;
    logic              emit_bit;
    logic              feedback;
    logic [OUT_W-1:0]  word_dat;
    logic              word_vld;
    logic              fifo_full;
    logic              pop;

    // A seed load pre-empts stepping in the same cycle.
    assign step_en  = lfsr_en & ~seed_load;
    assign emit_bit = lfsr[LFSR_W-1];
    assign feedback = ^(lfsr & TAPS);
    assign word_dat = {sr, emit_bit};
    assign word_vld = step_en & (cnt == LAST);
    assign pop      = out_val & out_rdy;

    assign lfsr_state = lfsr;

    // LFSR register; a zero seed would lock the register, so it is replaced by the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_DEFAULT;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED_DEFAULT : seed_in;
        end else if (step_en) begin
            lfsr <= {lfsr[LFSR_W-2:0], feedback};
        end
    end

    // Word assembly: shift in the emitted bit, restart the count on load or word completion.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            sr  <= '0;
            cnt <= '0;
        end else if (step_en) begin
            sr  <= word_dat[OUT_W-2:0];
            cnt <= word_vld ? '0 : cnt + 1'b1;
        end
    end

    // Sticky drop flag; cleared by reset or a reseed.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            overflow <= 1'b0;
        end else if (word_vld && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .W     (OUT_W),
        .DEPTH (2)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (word_vld),
        .wr_dat (word_dat),
        .full   (fifo_full),
        .rd_vld (out_val),
        .rd_rdy (out_rdy),
        .rd_dat (out_data)
    );
endmodule

// File: tb/tb_random_engine_dpath.sv
module tb_random_engine_dpath;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lfsr_en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        out_rdy = 1'b0;
    logic [7:0]  out_data;
    logic        out_val;
    logic        overflow;
    logic [15:0] lfsr_state;

    random_engine_dpath dut (
        .clk        (clk),
        .rst        (rst),
        .lfsr_en    (lfsr_en),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .out_data   (out_data),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .overflow   (overflow),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    string       phase = "init";

    // Reference: LFSR value, pending bits of the current word, queued words, sticky drop flag.
    logic [15:0] m_lfsr = SEED;
    bit          m_bits[$];
    logic [7:0]  m_q[$];
    bit          m_ovf = 1'b0;
    logic [7:0]  got_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %h expected %h (t=%0t)", phase, tag, got, exp, $time);
        end
    endtask

    // Plain reference sequence: state after n steps from a (remapped) seed.
    function automatic logic [15:0] ref_state(input logic [15:0] seed, input int n);
        logic [15:0] s;
        s = (seed == 16'h0) ? SEED : seed;
        for (int i = 0; i < n; i++) s = {s[14:0], ^(s & TAPS)};
        return s;
    endfunction

    task automatic model_edge(input bit r, input bit en, input bit ld, input logic [15:0] s, input bit rdy);
        bit         pop;
        bit         done;
        logic [7:0] w;
        if (r) begin
            m_lfsr = SEED;
            m_bits.delete();
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        pop  = (m_q.size() != 0) && rdy;
        done = 1'b0;
        w    = 8'h0;
        if (ld) begin
            m_lfsr = (s == 16'h0) ? SEED : s;
            m_bits.delete();
            m_ovf = 1'b0;
        end else if (en) begin
            m_bits.push_back(m_lfsr[15]);
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & TAPS)};
            if (m_bits.size() == 8) begin
                foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < 2) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit en, input bit ld, input logic [15:0] s, input bit rdy);
        rst = r; lfsr_en = en; seed_load = ld; seed_in = s; out_rdy = rdy;
        if (!r && out_val && rdy) got_log.push_back(out_data);
        @(posedge clk);
        model_edge(r, en, ld, s, rdy);
        @(negedge clk);
        chk("val",  32'(out_val),  32'(m_q.size() != 0));
        chk("data", 32'(out_data), 32'((m_q.size() != 0) ? m_q[0] : 8'h0));
        chk("ovf",  32'(overflow), 32'(m_ovf));
        chk("lfsr", 32'(lfsr_state), 32'(m_lfsr));
    endtask

    task automatic run(input int n, input bit en, input bit ld, input logic [15:0] s, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, en, ld, s, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        got_log.delete();
    endtask

    initial begin
        logic [15:0] st;
        logic [7:0]  w3;

        phase = "reset";
        do_reset();
        chk("rst_val",  32'(out_val), 'h0);
        chk("rst_data", 32'(out_data), 'h0);
        chk("rst_ovf",  32'(overflow), 'h0);
        chk("rst_lfsr", 32'(lfsr_state), 'hACE1);

        phase = "first_word";
        run(7, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("early_val", 32'(out_val), 'h0);
        run(1, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("w_val", 32'(out_val), 'h1);
        chk("w_dat", 32'(out_data), 'hAC);
        run(1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("one_cycle", 32'(out_val), 'h0);
        chk("n", 32'(got_log.size()), 'h1);
        chk("w0", 32'(got_log[0]), 'hAC);

        phase = "two_words";
        do_reset();
        run(16, 1'b1, 1'b0, 16'h0, 1'b1);
        st = ref_state(SEED, 16);
        chk("lfsr16", 32'(lfsr_state), 32'(st));
        run(2, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("n", 32'(got_log.size()), 'h2);
        chk("w0", 32'(got_log[0]), 'hAC);
        chk("w1", 32'(got_log[1]), 'hE1);

        phase = "seed1234";
        do_reset();
        step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        run(16, 1'b1, 1'b0, 16'h0, 1'b1);
        run(2, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("n", 32'(got_log.size()), 'h2);
        chk("w0", 32'(got_log[0]), 'h12);
        chk("w1", 32'(got_log[1]), 'h34);

        phase = "seed0";
        got_log.delete();
        step(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        chk("remap", 32'(lfsr_state), 'hACE1);
        run(16, 1'b1, 1'b0, 16'h0, 1'b1);
        run(2, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("n", 32'(got_log.size()), 'h2);
        chk("w0", 32'(got_log[0]), 'hAC);
        chk("w1", 32'(got_log[1]), 'hE1);

        phase = "overflow";
        do_reset();
        run(23, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("ovf23", 32'(overflow), 'h0);
        run(1, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("ovf24", 32'(overflow), 'h1);
        chk("head", 32'(out_data), 'hAC);
        run(3, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("n", 32'(got_log.size()), 'h2);
        chk("w0", 32'(got_log[0]), 'hAC);
        chk("w1", 32'(got_log[1]), 'hE1);
        chk("empty", 32'(out_val), 'h0);
        chk("sticky", 32'(overflow), 'h1);
        step(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1);
        chk("ld_clr", 32'(overflow), 'h0);

        phase = "partial_discard";
        do_reset();
        run(5, 1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hFF00, 1'b1);
        chk("ld_wins", 32'(lfsr_state), 'hFF00);
        run(7, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("no_early", 32'(out_val), 'h0);
        run(1, 1'b1, 1'b0, 16'h0, 1'b1);
        run(2, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("n", 32'(got_log.size()), 'h1);
        chk("w0", 32'(got_log[0]), 'hFF);

        phase = "full_push_pop";
        do_reset();
        run(16, 1'b1, 1'b0, 16'h0, 1'b0);
        run(7, 1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("no_ovf", 32'(overflow), 'h0);
        chk("head", 32'(out_data), 'hE1);
        run(3, 1'b0, 1'b0, 16'h0, 1'b1);
        st = ref_state(SEED, 16);
        w3 = st[15:8];
        chk("n", 32'(got_log.size()), 'h3);
        chk("w0", 32'(got_log[0]), 'hAC);
        chk("w1", 32'(got_log[1]), 'hE1);
        chk("w2", 32'(got_log[2]), 32'(w3));

        phase = "mid_reset";
        run(11, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("pre_val", 32'(out_val), 'h1);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("val",  32'(out_val), 'h0);
        chk("data", 32'(out_data), 'h0);
        chk("ovf",  32'(overflow), 'h0);
        chk("lfsr", 32'(lfsr_state), 'hACE1);
        run(8, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("fresh", 32'(out_data), 'hAC);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          en;
            bit          ld;
            bit          rdy;
            logic [15:0] s;
            r   = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            s   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            step(r, en, ld, s, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
